// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: fetch/decode/execute/memory/writeback sequencing with memory wait states.
// Optional JAL support is enabled by defining the JAL_EN macro.
module multicycle_control #(
    parameter int          ALU_OP_WIDTH = 3,
    parameter logic [2:0]  ALU_OP_ADD   = 3'b100,
    parameter logic [2:0]  ALU_OP_SUB   = 3'b001,
    parameter logic [2:0]  ALU_OP_OR    = 3'b101,
    parameter logic [2:0]  ALU_OP_AND   = 3'b110,
    parameter logic [2:0]  ALU_OP_RTYPE = 3'b111
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [5:0]              opcode_i,
    input  logic                    mem_ready_i,
    output logic                    pc_write_o,
    output logic                    branch_eq_o,
    output logic                    branch_ne_o,
    output logic                    i_or_d_o,
    output logic                    mem_read_o,
    output logic                    mem_write_o,
    output logic                    ir_write_o,
    output logic [1:0]              reg_dst_o,
    output logic [1:0]              mem_to_reg_o,
    output logic                    reg_write_o,
    output logic                    alu_src_a_o,
    output logic [1:0]              alu_src_b_o,
    output logic                    zero_ext_o,
    output logic [1:0]              pc_source_o,
    output logic [ALU_OP_WIDTH-1:0] alu_op_o,
    output logic                    illegal_op_o,
    output logic [3:0]              state_o
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_R_EXEC    = 4'd7,
        S_I_EXEC    = 4'd8,
        S_R_WB      = 4'd9,
        S_I_WB      = 4'd10,
        S_BRANCH    = 4'd11,
        S_JUMP      = 4'd12,
        S_JAL       = 4'd13
    } state_t;

    typedef struct packed {
        logic                    pc_write;
        logic                    branch_eq;
        logic                    branch_ne;
        logic                    i_or_d;
        logic                    mem_read;
        logic                    mem_write;
        logic [1:0]              reg_dst;
        logic [1:0]              mem_to_reg;
        logic                    reg_write;
        logic                    alu_src_a;
        logic [1:0]              alu_src_b;
        logic                    zero_ext;
        logic [1:0]              pc_source;
        logic [ALU_OP_WIDTH-1:0] alu_op;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    state_t     state_q;
    state_t     state_d;
    ctrl_t      ctrl_q;
    ctrl_t      ctrl_out;
    logic [3:0] state_raw;
    logic       state_known;
    logic       fetch_ack;

    function automatic state_t decode_next(input logic [5:0] op);
        state_t nxt;
        case (op)
            OP_RTYPE:                  nxt = S_R_EXEC;
            OP_ADDI, OP_ORI, OP_ANDI:  nxt = S_I_EXEC;
            OP_LW, OP_SW:              nxt = S_MEM_ADDR;
            OP_BEQ, OP_BNE:            nxt = S_BRANCH;
            OP_J:                      nxt = S_JUMP;
`ifdef JAL_EN
            OP_JAL:                    nxt = S_JAL;
`endif
            default:                   nxt = S_FETCH;
        endcase
        return nxt;
    endfunction

    function automatic logic opcode_legal(input logic [5:0] op);
        logic ok;
        case (op)
            OP_RTYPE, OP_ADDI, OP_ORI, OP_ANDI, OP_LW, OP_SW,
            OP_BEQ, OP_BNE, OP_J:      ok = 1'b1;
`ifdef JAL_EN
            OP_JAL:                    ok = 1'b1;
`endif
            default:                   ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Registered control word for the state being entered; opcode is already stable
    // when leaving DECODE, so I_EXEC and BRANCH strobes can be resolved here.
    function automatic ctrl_t ctrl_for(input state_t s, input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
                c.alu_op    = ALU_OP_WIDTH'(ALU_OP_ADD);
            end
            S_DECODE: begin
                c.alu_src_b = 2'b11;
                c.alu_op    = ALU_OP_WIDTH'(ALU_OP_ADD);
            end
            S_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_op    = ALU_OP_WIDTH'(ALU_OP_ADD);
            end
            S_MEM_READ: begin
                c.i_or_d   = 1'b1;
                c.mem_read = 1'b1;
            end
            S_MEM_WB: begin
                c.mem_to_reg = 2'b01;
                c.reg_write  = 1'b1;
            end
            S_MEM_WRITE: begin
                c.i_or_d    = 1'b1;
                c.mem_write = 1'b1;
            end
            S_R_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALU_OP_WIDTH'(ALU_OP_RTYPE);
            end
            S_I_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                case (op)
                    OP_ORI: begin
                        c.alu_op   = ALU_OP_WIDTH'(ALU_OP_OR);
                        c.zero_ext = 1'b1;
                    end
                    OP_ANDI: begin
                        c.alu_op   = ALU_OP_WIDTH'(ALU_OP_AND);
                        c.zero_ext = 1'b1;
                    end
                    default: c.alu_op = ALU_OP_WIDTH'(ALU_OP_ADD);
                endcase
            end
            S_R_WB: begin
                c.reg_dst   = 2'b01;
                c.reg_write = 1'b1;
                c.alu_op    = ALU_OP_WIDTH'(ALU_OP_RTYPE);
            end
            S_I_WB: begin
                c.reg_write = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALU_OP_WIDTH'(ALU_OP_SUB);
                c.pc_source = 2'b01;
                c.branch_eq = (op == OP_BEQ);
                c.branch_ne = (op == OP_BNE);
            end
            S_JUMP: begin
                c.pc_source = 2'b10;
                c.pc_write  = 1'b1;
            end
`ifdef JAL_EN
            S_JAL: begin
                c.pc_source  = 2'b10;
                c.pc_write   = 1'b1;
                c.reg_write  = 1'b1;
                c.reg_dst    = 2'b10;
                c.mem_to_reg = 2'b10;
            end
`endif
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_IDLE:      state_d = S_FETCH;
            S_FETCH:     state_d = mem_ready_i ? S_DECODE : S_FETCH;
            S_DECODE:    state_d = decode_next(opcode_i);
            S_MEM_ADDR:  state_d = (opcode_i == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  state_d = mem_ready_i ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: state_d = mem_ready_i ? S_FETCH : S_MEM_WRITE;
            S_R_EXEC:    state_d = S_R_WB;
            S_I_EXEC:    state_d = S_I_WB;
            default:     state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_for(state_d, opcode_i);
        end
    end

    assign state_raw = state_q;

    // Encodings past the last defined state never drive the datapath.
`ifdef JAL_EN
    assign state_known = (state_raw <= 4'd13);
`else
    assign state_known = (state_raw <= 4'd12);
`endif

    assign ctrl_out  = state_known ? ctrl_q : '0;
    assign fetch_ack = (state_q == S_FETCH) && mem_ready_i;

    assign pc_write_o   = ctrl_out.pc_write | fetch_ack;
    assign ir_write_o   = fetch_ack;
    assign branch_eq_o  = ctrl_out.branch_eq;
    assign branch_ne_o  = ctrl_out.branch_ne;
    assign i_or_d_o     = ctrl_out.i_or_d;
    assign mem_read_o   = ctrl_out.mem_read;
    assign mem_write_o  = ctrl_out.mem_write;
    assign reg_dst_o    = ctrl_out.reg_dst;
    assign mem_to_reg_o = ctrl_out.mem_to_reg;
    assign reg_write_o  = ctrl_out.reg_write;
    assign alu_src_a_o  = ctrl_out.alu_src_a;
    assign alu_src_b_o  = ctrl_out.alu_src_b;
    assign zero_ext_o   = ctrl_out.zero_ext;
    assign pc_source_o  = ctrl_out.pc_source;
    assign alu_op_o     = ctrl_out.alu_op;
    assign illegal_op_o = (state_q == S_DECODE) && !opcode_legal(opcode_i);
    assign state_o      = state_raw;

endmodule
